alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle ops with registered result and flags,
// plus iterative shift-add multiply and restoring divide on the same output port.
module alu_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_OP_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ALU_OP_BITS-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]  data1,
    input  logic [DATA_WIDTH-1:0]  data2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  alu_result,
    output logic [DATA_WIDTH-1:0]  alu_result_hi,
    output logic                   zero,
    output logic                   less,
    output logic                   greater,
    output logic                   less_s,
    output logic                   carry,
    output logic                   div_by_zero
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    localparam logic [ALU_OP_BITS-1:0] OP_ADD  = ALU_OP_BITS'(32'd0);
    localparam logic [ALU_OP_BITS-1:0] OP_SUB  = ALU_OP_BITS'(32'd1);
    localparam logic [ALU_OP_BITS-1:0] OP_NOT  = ALU_OP_BITS'(32'd2);
    localparam logic [ALU_OP_BITS-1:0] OP_AND  = ALU_OP_BITS'(32'd3);
    localparam logic [ALU_OP_BITS-1:0] OP_OR   = ALU_OP_BITS'(32'd4);
    localparam logic [ALU_OP_BITS-1:0] OP_NAND = ALU_OP_BITS'(32'd5);
    localparam logic [ALU_OP_BITS-1:0] OP_NOR  = ALU_OP_BITS'(32'd6);
    localparam logic [ALU_OP_BITS-1:0] OP_MOV  = ALU_OP_BITS'(32'd7);
    localparam logic [ALU_OP_BITS-1:0] OP_SAR  = ALU_OP_BITS'(32'd8);
    localparam logic [ALU_OP_BITS-1:0] OP_SHR  = ALU_OP_BITS'(32'd9);
    localparam logic [ALU_OP_BITS-1:0] OP_SHL  = ALU_OP_BITS'(32'd10);
    localparam logic [ALU_OP_BITS-1:0] OP_XOR  = ALU_OP_BITS'(32'd11);
    localparam logic [ALU_OP_BITS-1:0] OP_CMP  = ALU_OP_BITS'(32'd12);
    localparam logic [ALU_OP_BITS-1:0] OP_TEST = ALU_OP_BITS'(32'd13);
    localparam logic [ALU_OP_BITS-1:0] OP_MUL  = ALU_OP_BITS'(32'd14);
    localparam logic [ALU_OP_BITS-1:0] OP_DIV  = ALU_OP_BITS'(32'd15);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [SW-1:0]   cnt_r;
    logic [2*W-1:0]  acc_r;
    logic [W-1:0]    opnd_r;
    logic            dz_pend_r;

    logic            in_ready_s;
    logic            accept_s;
    logic            last_iter_s;
    logic [SW-1:0]   shamt_s;
    logic [W:0]      add_s;
    logic [W:0]      sub_s;
    logic [W-1:0]    sar_s;
    logic [W-1:0]    res_s;
    logic            carry_nx_s;
    logic            zero_nx_s;
    logic            less_nx_s;
    logic            greater_nx_s;
    logic            less_s_nx_s;
    logic [W:0]      mul_sum_s;
    logic [W:0]      div_trial_s;
    logic [2*W-1:0]  iter_next_s;

    assign in_ready_s  = (state_r == ST_IDLE) && (!out_valid || out_ready);
    assign in_ready    = in_ready_s;
    assign accept_s    = in_valid && in_ready_s;
    assign last_iter_s = (cnt_r == SW'(W - 1));
    assign shamt_s     = data2[SW-1:0];
    assign add_s       = {1'b0, data1} + {1'b0, data2};
    assign sub_s       = {1'b0, data1} - {1'b0, data2};
    assign sar_s       = $signed(data1) >>> shamt_s;

    // Multiply step: conditionally add multiplicand to the high half, then shift right.
    assign mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + {1'b0, (acc_r[0] ? opnd_r : {W{1'b0}})};
    // Divide step: trial-subtract divisor from the partial remainder with the next dividend bit.
    assign div_trial_s = {acc_r[2*W-1:W], acc_r[W-1]} - {1'b0, opnd_r};

    // Next value of the shared multiply/divide working register.
    always_comb begin
        iter_next_s = acc_r;
        if (state_r == ST_MUL) begin
            iter_next_s = {mul_sum_s, acc_r[W-1:1]};
        end else if (div_trial_s[W]) begin
            iter_next_s = {acc_r[2*W-2:0], 1'b0};
        end else begin
            iter_next_s = {div_trial_s[W-1:0], acc_r[W-2:0], 1'b1};
        end
    end

    // Single-cycle result and next flag values; flags not owned by an op are held.
    always_comb begin
        res_s        = {W{1'b0}};
        carry_nx_s   = carry;
        zero_nx_s    = zero;
        less_nx_s    = less;
        greater_nx_s = greater;
        less_s_nx_s  = less_s;
        case (alu_op)
            OP_ADD: begin
                res_s      = add_s[W-1:0];
                carry_nx_s = add_s[W];
            end
            OP_SUB: begin
                res_s      = sub_s[W-1:0];
                carry_nx_s = sub_s[W];
            end
            OP_NOT:  res_s = ~data1;
            OP_AND:  res_s = data1 & data2;
            OP_OR:   res_s = data1 | data2;
            OP_NAND: res_s = ~(data1 & data2);
            OP_NOR:  res_s = ~(data1 | data2);
            OP_MOV:  res_s = data1;
            OP_SAR:  res_s = sar_s;
            OP_SHR:  res_s = data1 >> shamt_s;
            OP_SHL:  res_s = data1 << shamt_s;
            OP_XOR:  res_s = data1 ^ data2;
            OP_CMP: begin
                res_s        = sub_s[W-1:0];
                zero_nx_s    = (data1 == data2);
                less_nx_s    = sub_s[W];
                greater_nx_s = !sub_s[W] && (data1 != data2);
                less_s_nx_s  = ($signed(data1) < $signed(data2));
            end
            OP_TEST: begin
                res_s        = data1 & data2;
                zero_nx_s    = ((data1 & data2) == {W{1'b0}});
                less_nx_s    = 1'b0;
                greater_nx_s = 1'b0;
                less_s_nx_s  = 1'b0;
            end
            default: res_s = {W{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (alu_op == OP_MUL)) begin
                    next_state_s = ST_MUL;
                end else if (accept_s && (alu_op == OP_DIV)) begin
                    next_state_s = ST_DIV;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_iter_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath and output registers; outputs only change on accept, completion or consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            alu_result    <= {W{1'b0}};
            alu_result_hi <= {W{1'b0}};
            zero          <= 1'b0;
            less          <= 1'b0;
            greater       <= 1'b0;
            less_s        <= 1'b0;
            carry         <= 1'b0;
            div_by_zero   <= 1'b0;
            cnt_r         <= {SW{1'b0}};
            acc_r         <= {(2*W){1'b0}};
            opnd_r        <= {W{1'b0}};
            dz_pend_r     <= 1'b0;
        end else if (accept_s) begin
            if (alu_op == OP_MUL) begin
                out_valid <= 1'b0;
                cnt_r     <= {SW{1'b0}};
                acc_r     <= {{W{1'b0}}, data2};
                opnd_r    <= data1;
                dz_pend_r <= 1'b0;
            end else if (alu_op == OP_DIV) begin
                out_valid <= 1'b0;
                cnt_r     <= {SW{1'b0}};
                acc_r     <= {{W{1'b0}}, data1};
                opnd_r    <= data2;
                dz_pend_r <= (data2 == {W{1'b0}});
            end else begin
                out_valid     <= 1'b1;
                alu_result    <= res_s;
                alu_result_hi <= {W{1'b0}};
                carry         <= carry_nx_s;
                zero          <= zero_nx_s;
                less          <= less_nx_s;
                greater       <= greater_nx_s;
                less_s        <= less_s_nx_s;
                div_by_zero   <= 1'b0;
            end
        end else if (state_r != ST_IDLE) begin
            acc_r <= iter_next_s;
            cnt_r <= cnt_r + SW'(1);
            if (last_iter_s) begin
                out_valid     <= 1'b1;
                alu_result    <= iter_next_s[W-1:0];
                alu_result_hi <= iter_next_s[2*W-1:W];
                div_by_zero   <= dz_pend_r;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq at W = 8, checked against an
// arithmetic reference model of the operation set and handshake timing.
module tb_alu_seq;
    localparam int W   = 8;
    localparam int MOD = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_op = 4'd0;
    logic [W-1:0] data1 = 8'd0;
    logic [W-1:0] data2 = 8'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_result;
    logic [W-1:0] alu_result_hi;
    logic         zero, less, greater, less_s, carry, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_carry, m_zero, m_less, m_greater, m_lts, m_dz;
    int unsigned e_lo, e_hi, e_lat;

    always #5 clk = ~clk;

    alu_seq #(.DATA_WIDTH(W), .ALU_OP_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .data1(data1), .data2(data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .alu_result_hi(alu_result_hi),
        .zero(zero), .less(less), .greater(greater), .less_s(less_s),
        .carry(carry), .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    task automatic model(input int op, input int unsigned a, input int unsigned b);
        int sa, sb;
        int unsigned s;
        sa = (a >= 128) ? int'(a) - MOD : int'(a);
        sb = (b >= 128) ? int'(b) - MOD : int'(b);
        s  = b % W;
        e_hi = 0;
        e_lat = 0;
        case (op)
            0:  begin e_lo = (a + b) % MOD; m_carry = ((a + b) >= MOD); end
            1:  begin e_lo = (a + MOD - b) % MOD; m_carry = (a < b); end
            2:  e_lo = (MOD - 1) - a;
            3:  e_lo = a & b;
            4:  e_lo = a | b;
            5:  e_lo = (MOD - 1) - (a & b);
            6:  e_lo = (MOD - 1) - (a | b);
            7:  e_lo = a;
            8:  e_lo = (sa >>> s) & (MOD - 1);
            9:  e_lo = a >> s;
            10: e_lo = (a << s) % MOD;
            11: e_lo = a ^ b;
            12: begin
                e_lo = (a + MOD - b) % MOD;
                m_zero = (a == b); m_less = (a < b); m_greater = (a > b); m_lts = (sa < sb);
            end
            13: begin
                e_lo = a & b;
                m_zero = (e_lo == 0); m_less = 0; m_greater = 0; m_lts = 0;
            end
            14: begin e_lo = (a * b) % MOD; e_hi = (a * b) / MOD; e_lat = W; end
            default: begin
                e_lat = W;
                if (b == 0) begin e_lo = MOD - 1; e_hi = a; end
                else begin e_lo = a / b; e_hi = a % b; end
            end
        endcase
        m_dz = (op == 15) && (b == 0);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int waited, output int lat, output int ir_seen);
        @(negedge clk);
        alu_op = op; data1 = a; data2 = b; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        ir_seen = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_seen++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input int op, input int unsigned a, input int unsigned b);
        int waited, lat, irs;
        model(op, a, b);
        do_op(4'(op), 8'(a), 8'(b), waited, lat, irs);
        check($sformatf("op%0d_issue_wait", op), 64'(waited), 64'd0);
        check($sformatf("op%0d_latency", op), 64'(lat), 64'(e_lat));
        check($sformatf("op%0d_busy_in_ready", op), 64'(irs), 64'd0);
        check($sformatf("op%0d_result %0d,%0d", op, a, b), 64'(alu_result), 64'(e_lo));
        check($sformatf("op%0d_result_hi %0d,%0d", op, a, b), 64'(alu_result_hi), 64'(e_hi));
        check($sformatf("op%0d_flags", op),
              64'({zero, less, greater, less_s, carry, div_by_zero}),
              64'({m_zero, m_less, m_greater, m_lts, m_carry, m_dz}));
    endtask

    initial begin
        int w, l, irs;
        logic [W-1:0] held;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_results", 64'({alu_result, alu_result_hi}), 64'd0);
        check("reset_flags", 64'({zero, less, greater, less_s, carry, div_by_zero}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // ADD / SUB carry behaviour
        run(0, 200, 100);
        check("add_200_100", 64'({carry, alu_result}), 64'({1'b1, 8'd44}));
        run(1, 5, 7);
        check("sub_5_7", 64'({carry, alu_result}), 64'({1'b1, 8'd254}));

        // CMP flags, then AND leaves them alone
        run(12, 8'h80, 8'h01);
        check("cmp_flags", 64'({less, greater, less_s, zero}), 64'(4'b0110));
        run(3, 8'hF0, 8'h3C);
        check("and_keeps_flags", 64'({less, greater, less_s, zero}), 64'(4'b0110));

        // Iterative ops
        run(14, 255, 255);
        check("mul_255_255", 64'({alu_result_hi, alu_result}), 64'({8'd254, 8'd1}));
        run(15, 200, 7);
        check("div_200_7", 64'({alu_result_hi, alu_result}), 64'({8'd4, 8'd28}));
        run(15, 9, 0);
        check("div_9_0", 64'({div_by_zero, alu_result_hi, alu_result}), 64'({1'b1, 8'd9, 8'd255}));
        run(0, 1, 2);
        check("dz_cleared", 64'(div_by_zero), 64'd0);

        // Output stall: drain, then hold out_ready low for 5 cycles
        @(negedge clk);
        @(posedge clk);
        #1;
        check("drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        model(0, 17, 25);
        do_op(4'd0, 8'd17, 8'd25, w, l, irs);
        check("stall_add_result", 64'(alu_result), 64'd42);
        held = alu_result;
        repeat (5) begin
            @(negedge clk);
            check("stall_result_stable", 64'(alu_result), 64'(held));
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        model(11, 8'h3C, 8'h0F);
        alu_op = 4'd11; data1 = 8'h3C; data2 = 8'h0F; in_valid = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_accept", 64'({out_valid, alu_result}), 64'({1'b1, 8'(e_lo)}));

        // Reset during a multiply
        @(negedge clk);
        alu_op = 4'd14; data1 = 8'd200; data2 = 8'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul_reset_valid", 64'(out_valid), 64'd0);
        check("midmul_reset_results", 64'({alu_result, alu_result_hi}), 64'd0);
        check("midmul_reset_flags", 64'({zero, less, greater, less_s, carry, div_by_zero}), 64'd0);
        {m_carry, m_zero, m_less, m_greater, m_lts, m_dz} = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run(10, 8'h01, 8'd3);
        check("shl_1_3", 64'(alu_result), 64'h08);

        // Randomized operations, back-to-back with out_ready held high
        repeat (80) begin
            int op;
            int unsigned a, b;
            op = int'($urandom_range(0, 15));
            a  = $urandom_range(0, MOD - 1);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MOD - 1);
            run(op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
